// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak/SHAKE front end.
// Covers lane width, SHAKE rates in lanes, padding bytes and the padder state encoding.
package keccak_pkg;

    localparam int w             = 64;
    localparam int RATE128_LANES = 21;
    localparam int RATE256_LANES = 17;

    localparam logic [7:0] DSEP_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_LAST   = 8'h80;

    typedef enum logic [1:0] {
        S_MSG  = 2'd0,
        S_DSEP = 2'd1,
        S_ZERO = 2'd2
    } pad_state_t;

    // mode 0 = SHAKE128, mode 1 = SHAKE256
    function automatic logic [4:0] rate_lanes(input logic mode);
        return mode ? 5'(RATE256_LANES) : 5'(RATE128_LANES);
    endfunction

endpackage

// File: rtl/shake_lane_pad.sv
// Combinational lane formatter: keeps bytes below n, inserts the SHAKE domain
// byte at position n (n < 8), and sets the final pad bit on a block-end padding lane.
module shake_lane_pad
    import keccak_pkg::*;
#(
    parameter int W = w
) (
    input  logic [W-1:0] lane_i,
    input  logic [3:0]   n_i,
    input  logic         is_block_end_i,
    input  logic         is_pad_i,
    output logic [W-1:0] lane_o
);

    localparam int NBYTES = W / 8;

    always_comb begin
        lane_o = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (4'(k) < n_i) begin
                lane_o[8*k +: 8] = lane_i[8*k +: 8];
            end else if (is_pad_i && (4'(k) == n_i)) begin
                lane_o[8*k +: 8] = DSEP_SHAKE;
            end
        end
        if (is_pad_i && is_block_end_i) begin
            lane_o[W-1 -: 8] = lane_o[W-1 -: 8] | PAD_LAST;
        end
    end

endmodule

// File: rtl/shake_padder.sv
// SHAKE128/256 message padder: passes message lanes through a one-entry output
// register and appends domain separation plus pad10*1 up to the rate-block boundary.
module shake_padder
    import keccak_pkg::*;
#(
    parameter int W = w
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode_i,
    input  logic         msg_valid_i,
    output logic         msg_ready_o,
    input  logic [W-1:0] msg_data_i,
    input  logic         msg_last_i,
    input  logic [3:0]   msg_bytes_i,
    output logic         pad_valid_o,
    input  logic         pad_ready_i,
    output logic [W-1:0] pad_data_o,
    output logic         pad_block_last_o,
    output logic         pad_msg_last_o
);

    pad_state_t   state_q, state_d;
    logic [4:0]   lane_q, lane_d;
    logic [4:0]   rate_q, rate_d;
    logic         active_q, active_d;
    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;
    logic         blast_q, blast_d;
    logic         mlast_q, mlast_d;

    logic         can_load;
    logic         load;
    logic         fin;
    logic [4:0]   rate_cur;
    logic         block_end;
    logic [3:0]   n_eff;
    logic [W-1:0] fmt_in;
    logic [3:0]   fmt_n;
    logic         fmt_is_pad;
    logic [W-1:0] fmt_out;

    shake_lane_pad #(.W(W)) u_lane_pad (
        .lane_i         (fmt_in),
        .n_i            (fmt_n),
        .is_block_end_i (block_end),
        .is_pad_i       (fmt_is_pad),
        .lane_o         (fmt_out)
    );

    // Rate comes from mode_i only on the first word of a message; afterwards it is latched.
    assign can_load  = !vld_q || pad_ready_i;
    assign rate_cur  = active_q ? rate_q : rate_lanes(mode_i);
    assign block_end = (lane_q == (rate_cur - 5'd1));
    assign n_eff     = (!msg_last_i || (msg_bytes_i > 4'd8)) ? 4'd8 : msg_bytes_i;

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        rate_d     = rate_q;
        active_d   = active_q;
        vld_d      = vld_q;
        data_d     = data_q;
        blast_d    = blast_q;
        mlast_d    = mlast_q;
        load       = 1'b0;
        fin        = 1'b0;
        fmt_in     = msg_data_i;
        fmt_n      = 4'd8;
        fmt_is_pad = 1'b0;

        if (vld_q && pad_ready_i) begin
            vld_d = 1'b0;
        end

        case (state_q)
            S_MSG: begin
                fmt_n      = n_eff;
                fmt_is_pad = msg_last_i && (n_eff < 4'd8);
                if (msg_valid_i && can_load) begin
                    load     = 1'b1;
                    active_d = 1'b1;
                    rate_d   = rate_cur;
                    if (msg_last_i) begin
                        if (n_eff == 4'd8) begin
                            state_d = S_DSEP;
                        end else if (block_end) begin
                            fin = 1'b1;
                        end else begin
                            state_d = S_ZERO;
                        end
                    end
                end
            end
            S_DSEP: begin
                fmt_in     = '0;
                fmt_n      = 4'd0;
                fmt_is_pad = 1'b1;
                if (can_load) begin
                    load = 1'b1;
                    if (block_end) begin
                        fin = 1'b1;
                    end else begin
                        state_d = S_ZERO;
                    end
                end
            end
            S_ZERO: begin
                fmt_in     = '0;
                fmt_n      = 4'd8;
                fmt_is_pad = 1'b1;
                if (can_load) begin
                    load = 1'b1;
                    fin  = block_end;
                end
            end
            default: begin
                state_d = S_MSG;
            end
        endcase

        if (load) begin
            vld_d   = 1'b1;
            data_d  = fmt_out;
            blast_d = block_end;
            mlast_d = fmt_is_pad && block_end;
            lane_d  = block_end ? 5'd0 : (lane_q + 5'd1);
        end

        if (fin) begin
            state_d  = S_MSG;
            lane_d   = 5'd0;
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_MSG;
            lane_q   <= 5'd0;
            rate_q   <= 5'(RATE128_LANES);
            active_q <= 1'b0;
            vld_q    <= 1'b0;
            data_q   <= '0;
            blast_q  <= 1'b0;
            mlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            rate_q   <= rate_d;
            active_q <= active_d;
            vld_q    <= vld_d;
            data_q   <= data_d;
            blast_q  <= blast_d;
            mlast_q  <= mlast_d;
        end
    end

    // Reset gates ready directly so upstream sees 0 for the whole time rst is low.
    assign msg_ready_o      = rst && (state_q == S_MSG) && can_load;
    assign pad_valid_o      = vld_q;
    assign pad_data_o       = data_q;
    assign pad_block_last_o = vld_q && blast_q;
    assign pad_msg_last_o   = vld_q && mlast_q;

endmodule
